instr_fetch_stage: RTL and testbench
====================================

Name: instr_fetch_stage

Overview:
- Fetch stage that owns the program counter register. It consumes the next-PC value produced by the PC select mux and issues requests to instruction memory.
- Buffers one returned instruction and hands it to decode over a valid/ready handshake.
- Supplies the current PC and PC+4 back to the PC adders and the mux, closing the PC loop.

Parameters:
- PC_SIZE, 32, width of PC and memory address.
- INST_SIZE, 32, instruction word width.
- RESET_PC, 32'h0000_0000, PC value loaded at reset.

Ports:
- i_clk  input  1  clock, all state on rising edge.
- i_rst_n  input  1  reset, asynchronous, active-low.
- i_next_pc  input  PC_SIZE  next PC from the PC select mux.
- i_redirect  input  1  non-sequential PC load (branch or exception); i_next_pc is valid this cycle.
- o_pc  output  PC_SIZE  current PC register.
- o_pc_plus_4  output  PC_SIZE  o_pc + 4, combinational, feeds mux add-4 leg.
- o_imem_req  output  1  instruction memory request.
- o_imem_addr  output  PC_SIZE  request address, registered.
- i_imem_ack  input  1  memory response; i_imem_rdata is valid this cycle.
- i_imem_rdata  input  INST_SIZE  fetched instruction word.
- o_inst_valid  output  1  buffered instruction available to decode.
- o_inst  output  INST_SIZE  buffered instruction.
- o_inst_pc  output  PC_SIZE  PC of o_inst.
- i_inst_ready  input  1  decode accepts the instruction.

Behaviour:
- Reset (async, i_rst_n=0):
  - pc=RESET_PC, addr=RESET_PC.
  - o_imem_req=0, o_inst_valid=0, o_inst=0, o_inst_pc=0, discard=0.
  - state=START.
- FSM states: START, FETCH, HOLD.
  - START: one cycle after reset deassertion; o_imem_req=0. Next state FETCH with addr=pc.
  - FETCH: o_imem_req=1 and o_imem_addr held stable until i_imem_ack. Request may be acked in the same cycle it is raised; memory latency is 1..N cycles.
  - FETCH + ack, discard=0, no redirect: buffer rdata into o_inst and addr into o_inst_pc; o_inst_valid=1; go to HOLD.
  - FETCH + ack, discard=1: drop the data; discard=0; addr=pc; stay in FETCH. The req pulse for the new address begins the next cycle.
  - FETCH + redirect, no ack: pc=i_next_pc; discard=1; req stays high with the old addr, as the memory protocol forbids withdrawal.
  - FETCH + redirect + ack the same cycle: drop the data; pc=i_next_pc; addr=i_next_pc; discard=0; stay in FETCH.
  - HOLD: o_inst_valid=1 with o_inst and o_inst_pc stable; o_imem_req=0.
  - HOLD + i_inst_ready, no redirect: pc=i_next_pc (the mux selects add-4 here, so this equals pc+4); addr=i_next_pc; o_inst_valid=0; go to FETCH.
  - HOLD + redirect (with or without ready): pc=i_next_pc; addr=i_next_pc; o_inst_valid=0; go to FETCH. If ready was also high, the instruction counts as consumed.
- i_redirect in START: pc=i_next_pc and addr=i_next_pc; go to FETCH.
- Throughput:
  - Peak is 1 instruction every 2 cycles (FETCH with zero-latency ack, then HOLD with ready).
  - Latency from addr issue to o_inst_valid is ack latency + 1 cycle.
- Arithmetic: o_pc_plus_4 is computed modulo 2^PC_SIZE, so 32'hFFFF_FFFC wraps to 0. No alignment checking; bit 0 of i_next_pc passes through unchanged.
- Reset asserted mid-operation forces reset values immediately. Any outstanding memory ack after reset is ignored, because state is START/FETCH with a fresh request.

Decomposition:
- Shared package cpu_pkg holds:
  - PC_SEL_ADD_4=2'b00, PC_SEL_ADD_IMM_SL_1=2'b01, PC_SEL_EXCEPTION=2'b10 (used by the controller that drives i_redirect).
  - Fetch FSM encodings START=2'd0, FETCH=2'd1, HOLD=2'd2.
  - Default RESET_PC.
- One natural sub-module: pc_reg, the PC register with load enable and async active-low reset. Everything else stays flat.

Test Plan:
- Reset release, ack same cycle as req, ready always 1 → o_imem_addr sequence 0x0,0x4,0x8; o_inst_valid every 2nd cycle; o_inst_pc matches the address.
- Ack latency 3 cycles → req held 3 cycles with addr stable at 0x4; o_inst_valid asserted the cycle after ack.
- Backpressure: ready=0 for 5 cycles in HOLD → o_inst and o_inst_pc stable, no new req; ready=1 → next req addr=0x8.
- Redirect in HOLD to 0x100 → o_inst_valid drops the next cycle; next req addr=0x100; o_inst_pc=0x100 on return.
- Redirect to 0x200 while req to 0xC is outstanding (ack 2 cycles later) → 0xC data never shown valid; next req addr=0x200.
- Reset asserted in HOLD with pc=0x40 → o_inst_valid=0, o_pc=0 asynchronously; after release, the first req addr is 0x0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch stage and the controller that
// drives the PC select mux.
//   PC_SEL_*          : PC select mux leg encodings (driven by the controller).
//   fetch_state_t     : fetch FSM state encoding.
//   DEFAULT_RESET_PC  : PC loaded on reset unless overridden.
package cpu_pkg;

  localparam logic [1:0] PC_SEL_ADD_4        = 2'b00;
  localparam logic [1:0] PC_SEL_ADD_IMM_SL_1 = 2'b01;
  localparam logic [1:0] PC_SEL_EXCEPTION    = 2'b10;

  typedef enum logic [1:0] {
    START = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/instr_fetch_stage_pc_reg.sv
// Program counter register with load enable.
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset, loads RESET_VAL
//   i_load    : capture i_d on the next rising edge
//   i_d       : value to load
//   o_q       : current register value
module pc_reg
  import cpu_pkg::*;
#(
  parameter int             W         = 32,
  parameter logic [W-1:0]   RESET_VAL = W'(DEFAULT_RESET_PC)
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= RESET_VAL;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/instr_fetch_stage.sv
// Instruction fetch stage: owns the PC, requests instruction memory, buffers
// one returned word and hands it to decode over valid/ready.
//   i_clk, i_rst_n           : clock (rising edge), async active-low reset
//   i_next_pc, i_redirect    : next PC from the select mux; redirect marks a
//                              non-sequential load valid this cycle
//   o_pc, o_pc_plus_4        : current PC and PC+4 (mod 2^PC_SIZE) to the mux
//   o_imem_req, o_imem_addr  : memory request and registered address
//   i_imem_ack, i_imem_rdata : memory response, data valid with ack
//   o_inst_valid, o_inst,
//   o_inst_pc, i_inst_ready  : buffered instruction handshake to decode
//
// state | meaning
// START | one idle cycle after reset, no request
// FETCH | request outstanding, address held until ack
// HOLD  | instruction buffered and presented to decode, no request
module instr_fetch_stage
  import cpu_pkg::*;
#(
  parameter int                 PC_SIZE   = 32,
  parameter int                 INST_SIZE = 32,
  parameter logic [PC_SIZE-1:0] RESET_PC  = PC_SIZE'(DEFAULT_RESET_PC)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [PC_SIZE-1:0]   i_next_pc,
  input  logic                 i_redirect,
  output logic [PC_SIZE-1:0]   o_pc,
  output logic [PC_SIZE-1:0]   o_pc_plus_4,
  output logic                 o_imem_req,
  output logic [PC_SIZE-1:0]   o_imem_addr,
  input  logic                 i_imem_ack,
  input  logic [INST_SIZE-1:0] i_imem_rdata,
  output logic                 o_inst_valid,
  output logic [INST_SIZE-1:0] o_inst,
  output logic [PC_SIZE-1:0]   o_inst_pc,
  input  logic                 i_inst_ready
);

  fetch_state_t         r_state, w_state_nxt;
  logic                 r_discard, w_discard_nxt;
  logic [PC_SIZE-1:0]   r_addr, w_addr_nxt;
  logic [INST_SIZE-1:0] r_inst;
  logic [PC_SIZE-1:0]   r_inst_pc;
  logic [PC_SIZE-1:0]   w_pc;
  logic                 w_pc_load;
  logic                 w_capture;
  logic                 w_imem_req;

  // Every PC load takes the mux output; in HOLD without redirect the mux is
  // on its add-4 leg, so the sequential case needs no separate path.
  pc_reg #(
    .W         (PC_SIZE),
    .RESET_VAL (RESET_PC)
  ) u_pc_reg (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_pc_load),
    .i_d     (i_next_pc),
    .o_q     (w_pc)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= START;
      r_discard <= 1'b0;
      r_addr    <= RESET_PC;
    end else begin
      r_state   <= w_state_nxt;
      r_discard <= w_discard_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_inst    <= '0;
      r_inst_pc <= '0;
    end else if (w_capture) begin
      r_inst    <= i_imem_rdata;
      r_inst_pc <= r_addr;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_discard_nxt = r_discard;
    w_addr_nxt    = r_addr;
    w_pc_load     = 1'b0;
    w_capture     = 1'b0;
    w_imem_req    = 1'b0;
    case (r_state)
      START: begin
        w_state_nxt = FETCH;
        if (i_redirect) begin
          w_pc_load  = 1'b1;
          w_addr_nxt = i_next_pc;
        end else begin
          w_addr_nxt = w_pc;
        end
      end
      FETCH: begin
        w_imem_req = 1'b1;
        if (i_imem_ack) begin
          if (i_redirect) begin
            // Response belongs to the abandoned path; reissue at the target.
            w_pc_load     = 1'b1;
            w_addr_nxt    = i_next_pc;
            w_discard_nxt = 1'b0;
          end else if (r_discard) begin
            // Stale response for a request raised before an earlier redirect.
            w_addr_nxt    = w_pc;
            w_discard_nxt = 1'b0;
          end else begin
            w_capture   = 1'b1;
            w_state_nxt = HOLD;
          end
        end else if (i_redirect) begin
          // The request cannot be withdrawn, so keep the old address up and
          // drop its data when it finally returns.
          w_pc_load     = 1'b1;
          w_discard_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (i_redirect || i_inst_ready) begin
          w_pc_load   = 1'b1;
          w_addr_nxt  = i_next_pc;
          w_state_nxt = FETCH;
        end
      end
      default: begin
        w_state_nxt = START;
      end
    endcase
  end

  assign o_pc         = w_pc;
  assign o_pc_plus_4  = w_pc + PC_SIZE'(4);
  assign o_imem_req   = w_imem_req;
  assign o_imem_addr  = r_addr;
  assign o_inst_valid = (r_state == HOLD);
  assign o_inst       = r_inst;
  assign o_inst_pc    = r_inst_pc;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Randomised bench for instr_fetch_stage. A memory model answers requests
// with random latency; the stimulus process plays the PC select mux and
// decode, pushing the PC of the next instruction decode must see; a monitor
// pops and checks each instruction as it is presented.
module tb_instr_fetch_stage;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] next_pc = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] o_pc, o_pc_plus_4, o_imem_addr, o_inst, o_inst_pc;
  logic        o_imem_req, o_inst_valid;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        ready = 1'b0;

  always #5 clk = ~clk;

  instr_fetch_stage #(
    .PC_SIZE   (32),
    .INST_SIZE (32),
    .RESET_PC  (RST_PC)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_next_pc    (next_pc),
    .i_redirect   (redirect),
    .o_pc         (o_pc),
    .o_pc_plus_4  (o_pc_plus_4),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_ack   (ack),
    .i_imem_rdata (rdata),
    .o_inst_valid (o_inst_valid),
    .o_inst       (o_inst),
    .o_inst_pc    (o_inst_pc),
    .i_inst_ready (ready)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
  endfunction

  logic [31:0] q_exp[$];
  int unsigned lat_max = 0;
  int unsigned ready_pct = 100;
  int unsigned redir_pct = 0;
  bit          peak = 1'b0;
  int          presented = 0;

  // Instruction memory: random 0..lat_max cycle latency, and a check that a
  // pending request is never withdrawn or moved.
  int unsigned lat = 0;
  bit          busy = 1'b0;
  bit          pend = 1'b0;
  logic [31:0] pend_addr = 32'h0;
  always @(negedge clk) begin
    if (!rst_n) begin
      ack  = 1'b0;
      busy = 1'b0;
      pend = 1'b0;
    end else begin
      if (pend) begin
        chk("req_held", {31'b0, o_imem_req}, 32'd1);
        chk("addr_stable", o_imem_addr, pend_addr);
      end
      ack   = 1'b0;
      rdata = $urandom;
      if (o_imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          lat  = $urandom_range(lat_max);
        end else begin
          lat = lat - 1;
        end
        if (lat == 0) begin
          ack   = 1'b1;
          rdata = memf(o_imem_addr);
          busy  = 1'b0;
        end
      end else begin
        busy = 1'b0;
      end
      pend      = o_imem_req && !ack;
      pend_addr = o_imem_addr;
    end
  end

  // Mux + decode: the next instruction decode must see is the redirect target
  // if one is issued, otherwise the consumed instruction's PC + 4.
  logic [31:0] last_pushed = RST_PC;
  always @(negedge clk) begin
    redirect = 1'b0;
    ready    = 1'b0;
    next_pc  = $urandom;
    if (!rst_n) begin
      q_exp.delete();
      q_exp.push_back(RST_PC);
      last_pushed = RST_PC;
    end else begin
      ready = ($urandom_range(99) < ready_pct);
      if ($urandom_range(99) < redir_pct) begin
        redirect = 1'b1;
        case ($urandom_range(3))
          0:       next_pc = 32'hFFFF_FFFC;
          1:       next_pc = 32'h100 + ($urandom_range(63) << 2);
          default: next_pc = $urandom;
        endcase
        // Not presenting: whatever is in flight is superseded by the target.
        if (!o_inst_valid && q_exp.size() > 0) void'(q_exp.pop_back());
        q_exp.push_back(next_pc);
        last_pushed = next_pc;
      end else if (o_inst_valid && ready) begin
        next_pc = last_pushed + 32'd4;
        q_exp.push_back(next_pc);
        last_pushed = next_pc;
      end
    end
  end

  // Monitor: checks each newly presented instruction and its stability.
  bit          prev_valid = 1'b0;
  bit          held_ok = 1'b0;
  int          cyc = 0;
  int          last_pres_cyc = 0;
  logic [31:0] held_pc = 32'h0;
  logic [31:0] held_inst = 32'h0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_valid    = 1'b0;
      held_ok       = 1'b0;
      last_pres_cyc = 0;
    end else begin
      if (o_inst_valid) chk("no_req_in_hold", {31'b0, o_imem_req}, 32'd0);
      if (o_inst_valid && !prev_valid) begin
        presented++;
        if (q_exp.size() == 0) begin
          checks++;
          failures++;
          held_ok = 1'b0;
          $display("FAIL unexpected_inst actual_pc=%h required=none", o_inst_pc);
        end else begin
          held_pc   = q_exp.pop_front();
          held_inst = memf(held_pc);
          held_ok   = 1'b1;
          chk("inst_pc", o_inst_pc, held_pc);
          chk("inst", o_inst, held_inst);
          chk("pc", o_pc, held_pc);
          chk("pc_plus_4", o_pc_plus_4, held_pc + 32'd4);
          if (peak && last_pres_cyc != 0) chk("peak_interval", cyc - last_pres_cyc, 32'd2);
          last_pres_cyc = cyc;
        end
      end else if (o_inst_valid && held_ok) begin
        chk("hold_inst", o_inst, held_inst);
        chk("hold_inst_pc", o_inst_pc, held_pc);
      end
      prev_valid = o_inst_valid;
    end
  end

  initial begin
    int n;
    rst_n = 1'b0;
    #1;
    chk("rst_req", {31'b0, o_imem_req}, 32'd0);
    chk("rst_valid", {31'b0, o_inst_valid}, 32'd0);
    chk("rst_inst", o_inst, 32'd0);
    chk("rst_inst_pc", o_inst_pc, 32'd0);
    chk("rst_pc", o_pc, RST_PC);
    chk("rst_addr", o_imem_addr, RST_PC);
    chk("rst_pc_plus_4", o_pc_plus_4, RST_PC + 32'd4);

    // Peak throughput: zero-latency memory, decode always ready.
    peak = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("start_no_req", {31'b0, o_imem_req}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'b0, o_imem_req}, 32'd1);
    chk("first_addr", o_imem_addr, RST_PC);
    repeat (40) @(negedge clk);

    // Latency, redirects and moderate backpressure.
    peak = 1'b0;
    lat_max = 3; ready_pct = 60; redir_pct = 15;
    repeat (400) @(negedge clk);

    // Heavy backpressure.
    lat_max = 2; ready_pct = 15; redir_pct = 8;
    repeat (300) @(negedge clk);

    // Reset asserted while holding an instruction.
    lat_max = 1; ready_pct = 0; redir_pct = 0;
    n = 0;
    while (!o_inst_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("reach_hold", {31'b0, o_inst_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'b0, o_inst_valid}, 32'd0);
    chk("midrst_pc", o_pc, RST_PC);
    chk("midrst_req", {31'b0, o_imem_req}, 32'd0);
    repeat (2) @(negedge clk);
    ready_pct = 100; lat_max = 3;
    #2 rst_n = 1'b1;
    #1 chk("restart_no_req", {31'b0, o_imem_req}, 32'd0);
    @(negedge clk);
    chk("restart_req", {31'b0, o_imem_req}, 32'd1);
    chk("restart_addr", o_imem_addr, RST_PC);
    repeat (60) @(negedge clk);

    chk("enough_insts", {31'b0, (presented > 50)}, 32'd1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
